// File: rtl/route_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// route_sequencer_pkg
// Shared definitions for the route sequencer and its junction counter:
//   - route ROM opcodes (STOP / FWD / LEFT / RIGHT; 4..7 are illegal)
//   - fault codes reported on fault_code
//   - line-tracker pattern that marks a junction
//   - sequencer FSM state encoding
// -----------------------------------------------------------------------------
package route_sequencer_pkg;

    localparam logic [2:0] OP_STOP  = 3'd0;
    localparam logic [2:0] OP_FWD   = 3'd1;
    localparam logic [2:0] OP_LEFT  = 3'd2;
    localparam logic [2:0] OP_RIGHT = 3'd3;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_TIMEOUT  = 2'd1;
    localparam logic [1:0] FC_TURN_ERR = 2'd2;
    localparam logic [1:0] FC_BAD_OP   = 2'd3;

    // All three tracker sensors on the line: the car is crossing a junction.
    localparam logic [2:0] DETECT_ALL = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ARM,
        S_RUN,
        S_SETTLE,
        S_DONE,
        S_FAULT
    } state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_RIGHT;
    endfunction

endpackage

// File: rtl/route_sequencer_junction_counter.sv
// -----------------------------------------------------------------------------
// junction_counter
// Counts rising edges of (detect == 3'b111) while en is high, saturating at 3.
// While en is low the count is cleared and the previous-value register is held
// at "line seen", so a junction already under the car on the first enabled
// cycle is never counted.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            count enable (low clears)
//   detect[2:0]   line tracker {L,C,R}
//   count[1:0]    junctions seen since en rose
// -----------------------------------------------------------------------------
module junction_counter
    import route_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] detect,
    output logic [1:0] count
);

    logic       hit;
    logic       prev_reg;
    logic [1:0] count_reg;

    assign hit = (detect == DETECT_ALL);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            count_reg <= '0;
            prev_reg  <= 1'b1;
        end else begin
            prev_reg <= hit;
            if (hit && !prev_reg && (count_reg != 2'd3)) begin
                count_reg <= count_reg + 2'd1;
            end
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/route_sequencer.sv
// -----------------------------------------------------------------------------
// route_sequencer
// Manoeuvre controller for the line-following car. Walks a route ROM (one
// {opcode, junction count} entry per manoeuvre), enables the matching
// manoeuvre block, waits for it to finish, drives straight for a settle gap
// and fetches the next entry. Faults on timeout, turn-block error or an
// illegal opcode.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, abort                route start pulse / level abort to IDLE
//   detect[2:0]                 line tracker {L,C,R}
//   rom_addr, rom_op, rom_cnt   route ROM (data valid one cycle after address)
//   en_left/en_right/en_fwd     one-hot manoeuvre enables
//   turn_count                  junction count for the active turn block
//   done_*/err_*                turn block status
//   busy, finished, fault, fault_code, step   route status
// -----------------------------------------------------------------------------
module route_sequencer
    import route_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 200_000_000,
    parameter int SETTLE_CYC  = 10_000_000,
    parameter int TO_W        = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        detect,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [2:0]        rom_op,
    input  logic [1:0]        rom_cnt,
    output logic              en_left,
    output logic              en_right,
    output logic              en_fwd,
    output logic [1:0]        turn_count,
    input  logic              done_left,
    input  logic              done_right,
    input  logic              err_left,
    input  logic              err_right,
    output logic              busy,
    output logic              finished,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic [ADDR_W-1:0] step
);

    localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] SETTLE_LAST  = TO_W'(SETTLE_CYC - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [2:0]        op_reg, op_next;
    logic [1:0]        turn_count_reg, turn_count_next;
    logic [TO_W-1:0]   timer_reg, timer_next;
    logic              fault_reg, fault_next;
    logic [1:0]        fault_code_reg, fault_code_next;

    logic       run_left, run_right, run_fwd;
    logic       run_done, run_err;
    logic [1:0] junction_count;

    assign run_left  = (state_reg == S_RUN) && (op_reg == OP_LEFT);
    assign run_right = (state_reg == S_RUN) && (op_reg == OP_RIGHT);
    assign run_fwd   = (state_reg == S_RUN) && (op_reg == OP_FWD);

    junction_counter u_junction_counter (
        .clk    (clk),
        .rst    (rst),
        .en     (run_fwd),
        .detect (detect),
        .count  (junction_count)
    );

    // Only the block that is actually enabled may finish or fault the step.
    assign run_done = (run_left  && done_left)  ||
                      (run_right && done_right) ||
                      (run_fwd   && (junction_count >= turn_count_reg));
    assign run_err  = (run_left && err_left) || (run_right && err_right);

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        op_next         = op_reg;
        turn_count_next = turn_count_reg;
        timer_next      = timer_reg;
        fault_next      = fault_reg;
        fault_code_next = fault_code_reg;

        if (abort) begin
            // Fault status survives an abort; only start or rst clears it.
            state_next      = S_IDLE;
            addr_next       = '0;
            turn_count_next = '0;
            timer_next      = '0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE, S_FAULT: begin
                    if (start) begin
                        state_next      = S_FETCH;
                        addr_next       = '0;
                        fault_next      = 1'b0;
                        fault_code_next = FC_NONE;
                    end
                end
                S_FETCH: begin
                    state_next = S_DECODE;
                end
                S_DECODE: begin
                    op_next = rom_op;
                    if (rom_op == OP_STOP) begin
                        state_next = S_DONE;
                    end else if (!op_is_legal(rom_op)) begin
                        state_next      = S_FAULT;
                        fault_next      = 1'b1;
                        fault_code_next = FC_BAD_OP;
                    end else begin
                        state_next      = S_ARM;
                        turn_count_next = rom_cnt;
                        timer_next      = '0;
                    end
                end
                S_ARM: begin
                    state_next = S_RUN;
                end
                S_RUN: begin
                    timer_next = timer_reg + TO_W'(1);
                    if (run_err) begin
                        state_next      = S_FAULT;
                        fault_next      = 1'b1;
                        fault_code_next = FC_TURN_ERR;
                    end else if (run_done) begin
                        // done beats a timeout landing on the same cycle
                        state_next = S_SETTLE;
                        timer_next = '0;
                    end else if (timer_reg == TIMEOUT_LAST) begin
                        state_next      = S_FAULT;
                        fault_next      = 1'b1;
                        fault_code_next = FC_TIMEOUT;
                    end
                end
                S_SETTLE: begin
                    if (timer_reg == SETTLE_LAST) begin
                        // Natural wrap at the top of the ROM.
                        addr_next  = addr_reg + ADDR_W'(1);
                        state_next = S_FETCH;
                    end else begin
                        timer_next = timer_reg + TO_W'(1);
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            addr_reg       <= '0;
            op_reg         <= OP_STOP;
            turn_count_reg <= '0;
            timer_reg      <= '0;
            fault_reg      <= 1'b0;
            fault_code_reg <= FC_NONE;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            op_reg         <= op_next;
            turn_count_reg <= turn_count_next;
            timer_reg      <= timer_next;
            fault_reg      <= fault_next;
            fault_code_reg <= fault_code_next;
        end
    end

    // Enables decode straight from state, so they drop on the RUN exit edge.
    assign en_left    = run_left;
    assign en_right   = run_right;
    assign en_fwd     = run_fwd || (state_reg == S_SETTLE);
    assign turn_count = turn_count_reg;
    assign rom_addr   = addr_reg;
    assign step       = addr_reg;
    assign busy       = !(state_reg inside {S_IDLE, S_DONE, S_FAULT});
    assign finished   = (state_reg == S_DONE);
    assign fault      = fault_reg;
    assign fault_code = fault_code_reg;

endmodule

// File: tb/tb_route_sequencer.sv
// -----------------------------------------------------------------------------
// tb_route_sequencer
// Directed and randomized routes against a route-level reference model that
// predicts cycle totals per enable, final step and fault code from the
// manoeuvre rules (fetch/decode/arm overheads, run lengths, settle gap).
// -----------------------------------------------------------------------------
module tb_route_sequencer;

    localparam int AW = 4;
    localparam int T  = 100;
    localparam int S  = 8;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [2:0]    detect;
    logic [AW-1:0] rom_addr, step;
    logic [2:0]    rom_op;
    logic [1:0]    rom_cnt, turn_count, fault_code;
    logic          en_left, en_right, en_fwd;
    logic          done_left, done_right, err_left, err_right;
    logic          busy, finished, fault;

    route_sequencer #(.ADDR_W(AW), .TIMEOUT_CYC(T), .SETTLE_CYC(S), .TO_W(28)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .detect(detect),
        .rom_addr(rom_addr), .rom_op(rom_op), .rom_cnt(rom_cnt),
        .en_left(en_left), .en_right(en_right), .en_fwd(en_fwd),
        .turn_count(turn_count), .done_left(done_left), .done_right(done_right),
        .err_left(err_left), .err_right(err_right), .busy(busy),
        .finished(finished), .fault(fault), .fault_code(fault_code), .step(step)
    );

    always #5 clk = ~clk;

    // Route ROM with one cycle of read latency.
    logic [2:0] rom_op_mem  [16];
    logic [1:0] rom_cnt_mem [16];
    always @(posedge clk) begin
        rom_op  <= rom_op_mem[rom_addr];
        rom_cnt <= rom_cnt_mem[rom_addr];
    end

    // Turn blocks: done rises once the enable has been high resp_delay cycles.
    int resp_delay = 1_000_000;
    int left_age = 0, right_age = 0, fwd_age = 0;
    always @(posedge clk) begin
        left_age  <= en_left  ? left_age + 1  : 0;
        right_age <= en_right ? right_age + 1 : 0;
        fwd_age   <= en_fwd   ? fwd_age + 1   : 0;
    end
    assign done_left  = en_left  && (left_age  == resp_delay);
    assign done_right = en_right && (right_age == resp_delay);

    // Line tracker replays det_pat from the cycle en_fwd rises.
    logic [2:0] det_pat [64];
    assign detect = en_fwd ? det_pat[fwd_age % 64] : 3'b000;

    // Per-cycle tallies, sampled on the falling edge.
    int mon_left = 0, mon_right = 0, mon_fwd = 0, mon_busy = 0, mon_multi = 0;
    always @(negedge clk) begin
        mon_left  <= mon_left  + int'(en_left);
        mon_right <= mon_right + int'(en_right);
        mon_fwd   <= mon_fwd   + int'(en_fwd);
        mon_busy  <= mon_busy  + int'(busy);
        mon_multi <= mon_multi + int'((int'(en_left) + int'(en_right) + int'(en_fwd)) > 1);
    end
    int snap_left, snap_right, snap_fwd, snap_busy, snap_multi;

    int n_total = 0, n_pass = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic exp_fault, input logic [1:0] exp_code);
        check({tag, "_outs"}, {rom_addr, step, en_left, en_right, en_fwd, turn_count, busy, finished}, 0);
        check({tag, "_fault"}, fault, exp_fault);
        check({tag, "_code"}, fault_code, exp_code);
    endtask

    // which: 0 en_left high, 1 finished or fault, 2 en_fwd high, 3 en_right high, 4 step==1
    task automatic wait_cond(input string tag, input int which, input int budget);
        int  n = 0;
        bit  ok = 0;
        while (1) begin
            case (which)
                0: ok = en_left;
                1: ok = finished || fault;
                2: ok = en_fwd;
                3: ok = en_right;
                default: ok = (step == 4'd1);
            endcase
            if (ok || n >= budget) break;
            @(negedge clk);
            n++;
        end
        check({tag, "_wait"}, ok, 1'b1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_route();
        snap_left = mon_left; snap_right = mon_right; snap_fwd = mon_fwd;
        snap_busy = mon_busy; snap_multi = mon_multi;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic int fwd_len(input int cnt);
        int   c = 0;
        logic prev = 1'b1;
        logic hit;
        for (int j = 1; j <= T; j++) begin
            if (c >= cnt) return j;
            hit = (det_pat[(j - 1) % 64] == 3'b111);
            if (j >= 2 && hit && !prev && c < 3) c++;
            prev = hit;
        end
        return -1;
    endfunction

    // Route-level prediction: per-entry overheads plus run length and settle.
    function automatic void model_route(output int busy_c, output int left_c, output int right_c,
                                        output int fwd_c, output int fin_step, output int code,
                                        output bit fin);
        int a = 0;
        int r;
        int op;
        busy_c = 0; left_c = 0; right_c = 0; fwd_c = 0; fin_step = 0; code = 0; fin = 0;
        for (int k = 0; k < 64; k++) begin
            op = int'(rom_op_mem[a]);
            busy_c += 2;
            fin_step = a;
            if (op == 0) begin fin = 1; return; end
            if (op > 3) begin code = 3; return; end
            busy_c += 1;
            if (op == 1) r = fwd_len(int'(rom_cnt_mem[a]));
            else r = (resp_delay + 1 <= T) ? resp_delay + 1 : -1;
            if (r < 0) begin
                busy_c += T;
                if (op == 1) fwd_c += T; else if (op == 2) left_c += T; else right_c += T;
                code = 1;
                return;
            end
            busy_c += r + S;
            if (op == 1) fwd_c += r; else if (op == 2) left_c += r; else right_c += r;
            fwd_c += S;
            a = (a + 1) % 16;
        end
    endfunction

    task automatic finish_and_compare(input string tag);
        int e_busy, e_left, e_right, e_fwd, e_step, e_code;
        bit e_fin;
        wait_cond(tag, 1, 3000);
        model_route(e_busy, e_left, e_right, e_fwd, e_step, e_code, e_fin);
        check({tag, "_busy_cyc"},  mon_busy  - snap_busy,  e_busy);
        check({tag, "_left_cyc"},  mon_left  - snap_left,  e_left);
        check({tag, "_right_cyc"}, mon_right - snap_right, e_right);
        check({tag, "_fwd_cyc"},   mon_fwd   - snap_fwd,   e_fwd);
        check({tag, "_multi_en"},  mon_multi - snap_multi, 0);
        check({tag, "_finished"},  finished, e_fin);
        check({tag, "_fault"},     fault, e_code != 0);
        check({tag, "_code"},      fault_code, e_code);
        check({tag, "_step"},      step, e_step);
        check({tag, "_en_off"},    {en_left, en_right, en_fwd}, 0);
        $display("%s: step=%0d finished=%0d fault_code=%0d busy_cycles=%0d",
                 tag, step, finished, fault_code, mon_busy - snap_busy);
    endtask

    task automatic load_route(input logic [2:0] op0, input logic [1:0] c0,
                              input logic [2:0] op1, input logic [1:0] c1);
        for (int i = 0; i < 16; i++) begin rom_op_mem[i] = 3'd0; rom_cnt_mem[i] = 2'd0; end
        rom_op_mem[0] = op0; rom_cnt_mem[0] = c0;
        rom_op_mem[1] = op1; rom_cnt_mem[1] = c1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; abort = 1'b0; err_left = 1'b0; err_right = 1'b0;
        for (int i = 0; i < 64; i++) det_pat[i] = 3'b000;
        load_route(3'd0, 2'd0, 3'd0, 2'd0);
        cycles(3);
        check_idle("reset", 1'b0, 2'd0);
        rst = 1'b0;
        cycles(2);

        // LEFT cnt1 answered 50 cycles after en_left; a start mid-run is ignored.
        load_route(3'd2, 2'd1, 3'd0, 2'd0);
        resp_delay = 50;
        start_route();
        wait_cond("left", 0, 20);
        check("left_turn_count", turn_count, 2'd1);
        cycles(10);
        start = 1'b1; @(negedge clk); start = 1'b0;
        finish_and_compare("left");
        check("left_en_cycles", mon_left - snap_left, 51);
        check("left_settle_cycles", mon_fwd - snap_fwd, 8);
        check("left_step", step, 4'd1);

        // FWD cnt2: held 111 counts once, first-cycle edge ignored.
        load_route(3'd1, 2'd2, 3'd0, 2'd0);
        det_pat[0] = 3'b111; det_pat[1] = 3'b111; det_pat[2] = 3'b010; det_pat[3] = 3'b111;
        det_pat[4] = 3'b111; det_pat[5] = 3'b111; det_pat[6] = 3'b000; det_pat[7] = 3'b111;
        for (int i = 8; i < 64; i++) det_pat[i] = 3'b111;
        start_route();
        finish_and_compare("fwd");
        check("fwd_en_cycles", mon_fwd - snap_fwd, 17);

        // RIGHT cnt3 never done: timeout after exactly T RUN cycles.
        load_route(3'd3, 2'd3, 3'd0, 2'd0);
        resp_delay = 1_000_000;
        start_route();
        wait_cond("timeout", 3, 20);
        check("timeout_turn_count", turn_count, 2'd3);
        finish_and_compare("timeout");
        check("timeout_right_cycles", mon_right - snap_right, T);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        check_idle("abort_in_fault", 1'b1, 2'd1);

        // err_right ignored on a LEFT step; err_left faults next cycle.
        load_route(3'd2, 2'd0, 3'd0, 2'd0);
        start_route();
        check("start_clears_fault", {fault, fault_code}, 3'b000);
        wait_cond("err", 0, 20);
        cycles(5);
        err_right = 1'b1; @(negedge clk); err_right = 1'b0;
        check("err_right_ignored", {en_left, fault}, 2'b10);
        cycles(3);
        err_left = 1'b1; @(negedge clk); err_left = 1'b0;
        check("err_left_fault", {fault, fault_code, en_left}, 4'b1100);
        check("err_left_step", step, 4'd0);

        // Illegal opcode at address 2, then a clean restart.
        load_route(3'd1, 2'd0, 3'd1, 2'd0);
        rom_op_mem[2] = 3'd5;
        start_route();
        finish_and_compare("badop");
        load_route(3'd2, 2'd2, 3'd0, 2'd0);
        resp_delay = 4;
        start_route();
        check("restart_status", {fault, fault_code, rom_addr, busy}, {3'b000, 4'd0, 1'b1});
        finish_and_compare("restart");

        // abort mid-RUN.
        resp_delay = 1_000_000;
        start_route();
        wait_cond("abort", 0, 20);
        cycles(4);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        check_idle("abort_run", 1'b0, 2'd0);
        resp_delay = 7;
        start_route();
        finish_and_compare("after_abort");

        // rst mid-SETTLE.
        resp_delay = 3;
        start_route();
        wait_cond("rst_settle", 2, 40);
        cycles(3);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        check_idle("rst_settle", 1'b0, 2'd0);
        resp_delay = 2;
        start_route();
        finish_and_compare("after_rst");

        // Address wrap: 16 FWD cnt0 entries, then entry 0 becomes STOP.
        for (int i = 0; i < 16; i++) begin rom_op_mem[i] = 3'd1; rom_cnt_mem[i] = 2'd0; end
        start_route();
        wait_cond("wrap_step1", 4, 40);
        rom_op_mem[0] = 3'd0;
        wait_cond("wrap", 1, 400);
        check("wrap_finished", {finished, fault}, 2'b10);
        check("wrap_step", step, 4'd0);
        check("wrap_busy_cyc", mon_busy - snap_busy, 16 * (4 + S) + 2);
        check("wrap_fwd_cyc", mon_fwd - snap_fwd, 16 * (1 + S));
        $display("wrap: step=%0d finished=%0d busy_cycles=%0d", step, finished, mon_busy - snap_busy);

        // Randomized routes.
        for (int it = 0; it < 8; it++) begin
            int r;
            n = $urandom_range(5, 1);
            for (int i = 0; i < 16; i++) begin rom_op_mem[i] = 3'd0; rom_cnt_mem[i] = 2'd0; end
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(7, 0);
                rom_op_mem[i]  = (r < 7) ? 3'(1 + r % 3) : 3'($urandom_range(7, 4));
                rom_cnt_mem[i] = 2'($urandom_range(3, 0));
            end
            resp_delay = ($urandom_range(5, 0) == 0) ? 120 : $urandom_range(40, 0);
            for (int i = 0; i < 64; i++)
                det_pat[i] = ($urandom_range(1, 0) == 1) ? 3'b111 : 3'($urandom_range(6, 0));
            start_route();
            finish_and_compare($sformatf("rand%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
